// File: rtl/mult_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter_if
//
// Purpose: bundles the requester-side and multiplier-side signals of
// mult_share_arbiter so the arbiter, its requesters and the shared multiplier
// connect through one port.
//
// Signals (names as seen by the arbiter):
//   req         requester -> arb  level request per requester
//   req_a/b     requester -> arb  operand slices, slice i = [i*DP_WIDTH +: DP_WIDTH]
//   gnt         arb -> requester  one-hot single-cycle acceptance pulse
//   done        arb -> requester  one-hot single-cycle completion pulse
//   result      arb -> requester  last completed product
//   result_id   arb -> requester  requester index of result
//   busy        arb -> requester  arbiter is not idle
//   mul_start   arb -> mul        start request to the multiplier
//   mul_a/b     arb -> mul        operands, held for the whole operation
//   mul_rdy     mul -> arb        multiplier idle flag
//   mul_product mul -> arb        product, valid when mul_rdy rises after an op
//
// Handshake semantics:
//   Requester side: req[i] is the "valid" and is held (with its operands) until
//   gnt[i] is seen; gnt[i] is the one-cycle "ready" acknowledgement, after which
//   the operands may change freely. done[i] pulses once per accepted request.
//   Multiplier side: mul_start is held high until mul_rdy is sampled low (the
//   multiplier has taken the operation); the product is taken on the first
//   cycle mul_rdy is sampled high again.
//
// Modports: slave = the arbiter's view, master = the environment's view.
// -----------------------------------------------------------------------------
interface mult_share_arbiter_if #(
  parameter int N_REQ    = 4,
  parameter int DP_WIDTH = 8,
  parameter int ID_W     = $clog2(N_REQ)
);
  logic [N_REQ-1:0]          req;
  logic [N_REQ*DP_WIDTH-1:0] req_a;
  logic [N_REQ*DP_WIDTH-1:0] req_b;
  logic [N_REQ-1:0]          gnt;
  logic [N_REQ-1:0]          done;
  logic [2*DP_WIDTH-1:0]     result;
  logic [ID_W-1:0]           result_id;
  logic                      busy;
  logic                      mul_start;
  logic [DP_WIDTH-1:0]       mul_a;
  logic [DP_WIDTH-1:0]       mul_b;
  logic                      mul_rdy;
  logic [2*DP_WIDTH-1:0]     mul_product;

  modport slave (
    input  req, req_a, req_b, mul_rdy, mul_product,
    output gnt, done, result, result_id, busy, mul_start, mul_a, mul_b
  );

  modport master (
    output req, req_a, req_b, mul_rdy, mul_product,
    input  gnt, done, result, result_id, busy, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
//
// Purpose: shares one sequential shift-add multiplier between N_REQ requesters.
// Requests are accepted round-robin, the winner's operands are latched and
// launched on the multiplier, and the product is returned with a done pulse
// tagged with the requester index.
//
// Ports:
//   clk          rising-edge clock
//   rstb         asynchronous active-low reset (shared with the multiplier)
//   bus          mult_share_arbiter_if.slave, requester and multiplier signals
//   dbg_state_o  current FSM state (0 idle, 1 start, 2 busy, 3 done)
//
// Operation sequence: S_IDLE -> S_START -> S_BUSY -> S_DONE -> S_IDLE.
// All outputs are registered; gnt and done are single-cycle pulses.
// -----------------------------------------------------------------------------
module mult_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DP_WIDTH = 8,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rstb,
  mult_share_arbiter_if.slave  bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                state_q;
  logic [ID_W-1:0]       rr_ptr_q;
  logic [ID_W-1:0]       owner_q;
  logic [DP_WIDTH-1:0]   op_a_q;
  logic [DP_WIDTH-1:0]   op_b_q;
  logic [N_REQ-1:0]      gnt_q;
  logic [N_REQ-1:0]      done_q;
  logic [2*DP_WIDTH-1:0] result_q;
  logic [ID_W-1:0]       result_id_q;
  logic                  busy_q;
  logic                  mul_start_q;

  // ---------------------------------------------------------------------------
  // Round-robin winner selection
  // Scans rr_ptr, rr_ptr+1, ... modulo N_REQ and picks the first set request.
  // The modulo is done on int so non-power-of-two N_REQ wraps correctly.
  // ---------------------------------------------------------------------------
  logic                  win_vld_d;
  logic [ID_W-1:0]       win_idx_d;
  logic [DP_WIDTH-1:0]   win_a_d;
  logic [DP_WIDTH-1:0]   win_b_d;
  logic [ID_W-1:0]       rr_ptr_d;

  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld_d && bus.req[(int'(rr_ptr_q) + i) % N_REQ]) begin
        win_vld_d = 1'b1;
        win_idx_d = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
      end
    end
  end

  assign win_a_d = bus.req_a[int'(win_idx_d)*DP_WIDTH +: DP_WIDTH];
  assign win_b_d = bus.req_b[int'(win_idx_d)*DP_WIDTH +: DP_WIDTH];

  // Pointer moves just past the requester that was served.
  assign rr_ptr_d = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      result_q    <= '0;
      result_id_q <= '0;
      busy_q      <= 1'b0;
      mul_start_q <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one cycle.
      gnt_q  <= '0;
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          // Only accept when the multiplier is idle, so an operation is never
          // launched on top of one still running.
          if (win_vld_d && bus.mul_rdy) begin
            owner_q     <= win_idx_d;
            op_a_q      <= win_a_d;
            op_b_q      <= win_b_d;
            gnt_q       <= ONE_HOT0 << win_idx_d;
            mul_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_START;
          end
        end
        S_START: begin
          // mul_rdy falling means the multiplier has taken the operands.
          if (!bus.mul_rdy) begin
            mul_start_q <= 1'b0;
            state_q     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.mul_rdy) begin
            result_q    <= bus.mul_product;
            result_id_q <= owner_q;
            done_q      <= ONE_HOT0 << owner_q;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          rr_ptr_q <= rr_ptr_d;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // Operands come from the private copies latched at accept, so requester
  // changes after gnt cannot disturb the operation in flight.
  // ---------------------------------------------------------------------------
  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.result_id = result_id_q;
  assign bus.busy      = busy_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_a     = op_a_q;
  assign bus.mul_b     = op_b_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;
  localparam int N_REQ    = 4;
  localparam int DP_WIDTH = 8;
  localparam int ID_W     = 2;
  localparam int PW       = 2*DP_WIDTH;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk  = 1'b0;
  logic       rstb = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  mult_share_arbiter_if #(.N_REQ(N_REQ), .DP_WIDTH(DP_WIDTH), .ID_W(ID_W)) bus();

  mult_share_arbiter #(.N_REQ(N_REQ), .DP_WIDTH(DP_WIDTH), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Multiplier stub: 1 load cycle + 2 cycles per bit, product formed from the
  // operands present at the end so operand instability shows in the result.
  // ---------------------------------------------------------------------------
  logic          m_busy;
  logic [5:0]    m_cnt;
  logic [PW-1:0] m_prod;
  logic          force_low = 1'b0;

  assign bus.mul_rdy     = !m_busy && !force_low;
  assign bus.mul_product = m_prod;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_busy <= 1'b0;
      m_cnt  <= '0;
      m_prod <= '0;
    end else if (!m_busy && !force_low && bus.mul_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 6'(2*DP_WIDTH);
    end else if (m_busy) begin
      if (m_cnt == 6'd1) begin
        m_busy <= 1'b0;
        m_prod <= PW'(bus.mul_a) * PW'(bus.mul_b);
      end
      m_cnt <= m_cnt - 6'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: logs pulses at the falling edge
  // ---------------------------------------------------------------------------
  int              cyc = 0;
  logic [3:0]      gnt_log[$];
  int              gnt_cyc[$];
  logic [3:0]      done_vec_log[$];
  int              done_id_log[$];
  logic [PW-1:0]   done_res_log[$];
  int              done_cyc[$];
  logic            busy_after_done[$];
  logic [3:0]      prev_done = '0;

  always @(negedge clk) begin
    cyc++;
    if (bus.gnt != '0) begin
      gnt_log.push_back(bus.gnt);
      gnt_cyc.push_back(cyc);
    end
    if (bus.done != '0) begin
      done_vec_log.push_back(bus.done);
      done_id_log.push_back(int'(bus.result_id));
      done_res_log.push_back(bus.result);
      done_cyc.push_back(cyc);
    end
    if (prev_done != '0) busy_after_done.push_back(bus.busy);
    prev_done = bus.done;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard counters and expected queue
  // ---------------------------------------------------------------------------
  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] exp_q[$];
  logic [3:0]    drop_mask = 4'hF;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic clear_logs();
    gnt_log.delete();
    gnt_cyc.delete();
    done_vec_log.delete();
    done_id_log.delete();
    done_res_log.delete();
    done_cyc.delete();
    busy_after_done.delete();
  endtask

  // One cycle; requesters in drop_mask release req when they see their gnt.
  task automatic step();
    @(negedge clk);
    #1;
    bus.req = bus.req & ~(bus.gnt & drop_mask);
  endtask

  task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[idx*DP_WIDTH +: DP_WIDTH] = a;
    bus.req_b[idx*DP_WIDTH +: DP_WIDTH] = b;
  endtask

  task automatic do_reset();
    rstb      = 1'b0;
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    force_low = 1'b0;
    drop_mask = 4'hF;
    repeat (2) @(negedge clk);
    clear_logs();
    #1;
    rstb = 1'b1;
    step();
  endtask

  task automatic wait_dones(input int n, input int budget, output bit ok);
    for (int k = 0; k < budget && done_id_log.size() < n; k++) step();
    ok = (done_id_log.size() >= n);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    bus.req = '0; bus.req_a = '0; bus.req_b = '0;
    @(negedge clk);
    rstb = 1'b0;
    #1;
    checks++;
    if ({bus.gnt, bus.done, bus.result, bus.result_id, bus.busy, bus.mul_start,
         bus.mul_a, bus.mul_b, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs actual gnt=%b done=%b result=%0d id=%0d busy=%b start=%b a=%0d b=%0d state=%0d required all 0",
               bus.gnt, bus.done, bus.result, bus.result_id, bus.busy, bus.mul_start,
               bus.mul_a, bus.mul_b, dbg_state);
    end
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.busy !== 1'b0 || bus.gnt !== 4'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL idle_no_req actual busy=%b gnt=%b state=%0d required 0 0 0",
               bus.busy, bus.gnt, dbg_state);
    end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    set_ops(1, 8'd13, 8'd11);
    bus.req = 4'b0010;
    wait_dones(1, 60, ok);
    repeat (3) step();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_timeout actual no done required done within 60 cycles");
    end else begin
      checks++;
      if (gnt_log.size() != 1 || gnt_log[0] !== 4'b0010) begin
        errors++;
        $display("FAIL single_gnt actual count=%0d first=%b required count=1 gnt=0010",
                 gnt_log.size(), gnt_log[0]);
      end
      checks++;
      if (done_vec_log.size() != 1 || done_vec_log[0] !== 4'b0010) begin
        errors++;
        $display("FAIL single_done actual count=%0d vec=%b required count=1 vec=0010",
                 done_vec_log.size(), done_vec_log[0]);
      end
      checks++;
      if (done_res_log[0] !== 16'd143 || done_id_log[0] != 1) begin
        errors++;
        $display("FAIL single_result actual result=%0d id=%0d required 143 1",
                 done_res_log[0], done_id_log[0]);
      end
      checks++;
      if (busy_after_done.size() < 1 || busy_after_done[0] !== 1'b0) begin
        errors++;
        $display("FAIL single_busy_fall actual busy=%b required 0 the cycle after done",
                 busy_after_done[0]);
      end
      checks++;
      if (done_cyc[0] - gnt_cyc[0] < 2*DP_WIDTH || done_cyc[0] - gnt_cyc[0] > 2*DP_WIDTH + 3) begin
        errors++;
        $display("FAIL single_latency actual %0d required %0d..%0d",
                 done_cyc[0] - gnt_cyc[0], 2*DP_WIDTH, 2*DP_WIDTH + 3);
      end
      checks++;
      if (bus.result !== 16'd143 || bus.result_id !== 2'd1 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL single_hold actual result=%0d id=%0d busy=%b required 143 1 0",
                 bus.result, bus.result_id, bus.busy);
      end
    end
  endtask

  task automatic test_all_four();
    bit ok;
    do_reset();
    set_ops(0, 8'd3,   8'd5);
    set_ops(1, 8'd7,   8'd9);
    set_ops(2, 8'd255, 8'd255);
    set_ops(3, 8'd0,   8'd200);
    exp_q = '{16'd15, 16'd63, 16'd65025, 16'd0};
    bus.req = 4'b1111;
    wait_dones(4, 200, ok);
    repeat (10) step();
    checks++;
    if (!ok || done_id_log.size() != 4 || gnt_log.size() != 4) begin
      errors++;
      $display("FAIL all4_count actual dones=%0d gnts=%0d required 4 4",
               done_id_log.size(), gnt_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic [3:0]    exp_vec;
        logic [PW-1:0] exp_res;
        exp_vec = 4'b0001 << i;
        exp_res = exp_q.pop_front();
        checks++;
        if (gnt_log[i] !== exp_vec || done_vec_log[i] !== exp_vec) begin
          errors++;
          $display("FAIL all4_order[%0d] actual gnt=%b done=%b required %b", i,
                   gnt_log[i], done_vec_log[i], exp_vec);
        end
        checks++;
        if (done_res_log[i] !== exp_res || done_id_log[i] != i) begin
          errors++;
          $display("FAIL all4_result[%0d] actual result=%0d id=%0d required %0d %0d", i,
                   done_res_log[i], done_id_log[i], exp_res, i);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    drop_mask = 4'b1010;
    set_ops(0, 8'd2,  8'd3);
    set_ops(2, 8'd10, 8'd10);
    bus.req = 4'b0101;
    wait_dones(4, 200, ok);
    bus.req = '0;
    repeat (5) step();
    checks++;
    if (!ok || gnt_log.size() != 4) begin
      errors++;
      $display("FAIL rr_count actual gnts=%0d required 4", gnt_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic [3:0]    exp_vec;
        logic [PW-1:0] exp_res;
        exp_vec = (i % 2 == 0) ? 4'b0001 : 4'b0100;
        exp_res = (i % 2 == 0) ? 16'd6 : 16'd100;
        checks++;
        if (gnt_log[i] !== exp_vec || done_res_log[i] !== exp_res) begin
          errors++;
          $display("FAIL rr_alt[%0d] actual gnt=%b result=%0d required %b %0d", i,
                   gnt_log[i], done_res_log[i], exp_vec, exp_res);
        end
      end
    end
  endtask

  task automatic test_operand_change();
    bit ok;
    do_reset();
    set_ops(1, 8'd6, 8'd7);
    bus.req = 4'b0010;
    for (int k = 0; k < 20 && gnt_log.size() == 0; k++) step();
    step();
    set_ops(1, 8'd9, 8'd7);
    wait_dones(1, 60, ok);
    checks++;
    if (!ok || done_res_log[0] !== 16'd42 || done_id_log[0] != 1) begin
      errors++;
      $display("FAIL op_change actual ok=%0d result=%0d id=%0d required 1 42 1",
               ok, done_res_log[0], done_id_log[0]);
    end
  endtask

  task automatic test_mul_busy();
    bit ok;
    do_reset();
    force_low = 1'b1;
    set_ops(0, 8'd12, 8'd12);
    bus.req = 4'b0001;
    repeat (10) step();
    checks++;
    if (gnt_log.size() != 0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL mulbusy_hold actual gnts=%0d state=%0d required 0 0",
               gnt_log.size(), dbg_state);
    end
    force_low = 1'b0;
    step();
    checks++;
    if (gnt_log.size() != 1 || gnt_log[0] !== 4'b0001) begin
      errors++;
      $display("FAIL mulbusy_gnt actual count=%0d gnt=%b required 1 0001",
               gnt_log.size(), gnt_log[0]);
    end
    wait_dones(1, 60, ok);
    checks++;
    if (!ok || done_res_log[0] !== 16'd144) begin
      errors++;
      $display("FAIL mulbusy_result actual ok=%0d result=%0d required 1 144",
               ok, done_res_log[0]);
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    bit reached;
    do_reset();
    set_ops(0, 8'd1, 8'd1);
    set_ops(3, 8'd4, 8'd5);
    bus.req = 4'b1001;
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      step();
      reached = (dbg_state == 2'd2);
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL midrst_reach_busy actual state=%0d required 2", dbg_state);
    end
    rstb = 1'b0;
    #1;
    checks++;
    if ({bus.gnt, bus.done, bus.result, bus.result_id, bus.busy, bus.mul_start,
         bus.mul_a, bus.mul_b, dbg_state} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs actual busy=%b start=%b a=%0d b=%0d state=%0d required all 0",
               bus.busy, bus.mul_start, bus.mul_a, bus.mul_b, dbg_state);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_id_log.size() != 0) begin
      errors++;
      $display("FAIL midrst_no_done actual dones=%0d required 0", done_id_log.size());
    end
    clear_logs();
    #1;
    rstb = 1'b1;
    wait_dones(1, 60, ok);
    checks++;
    if (!ok || gnt_log[0] !== 4'b1000 || done_id_log[0] != 3 || done_res_log[0] !== 16'd20) begin
      errors++;
      $display("FAIL midrst_pending actual ok=%0d gnt=%b id=%0d result=%0d required 1 1000 3 20",
               ok, gnt_log[0], done_id_log[0], done_res_log[0]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    test_reset();
    test_single();
    test_all_four();
    test_round_robin();
    test_operand_change();
    test_mul_busy();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one sequential shift-add multiplier between N_REQ requesters.
- Each requester has a start/operand pair. The block grants requesters round-robin and launches the multiplier with the start/rdy handshake. It then returns the 2*DP_WIDTH product with a done pulse tagged by requester index.
- Sits between the requesting control units and the single multiplier instance. No requester drives the multiplier directly.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DP_WIDTH, 8, operand width of the shared multiplier.
- ID_W, $clog2(N_REQ), width of the requester index.

Ports:
- clk  input  1  rising-edge clock.
- rstb  input  1  asynchronous active-low reset.
- req  input  N_REQ  request per requester, level; held until the matching gnt bit is seen.
- req_a  input  N_REQ*DP_WIDTH  multiplicand per requester; slice i is bits [i*DP_WIDTH +: DP_WIDTH].
- req_b  input  N_REQ*DP_WIDTH  multiplier per requester, same slicing.
- gnt  output  N_REQ  one-hot, single-cycle acceptance pulse.
- done  output  N_REQ  one-hot, single-cycle completion pulse.
- result  output  2*DP_WIDTH  last completed product.
- result_id  output  ID_W  requester index of result.
- busy  output  1  high whenever the state is not S_IDLE.
- mul_start  output  1  start to the multiplier.
- mul_a  output  DP_WIDTH  multiplicand to the multiplier.
- mul_b  output  DP_WIDTH  multiplier operand to the multiplier.
- mul_rdy  input  1  multiplier idle flag (high in the multiplier's idle state).
- mul_product  input  2*DP_WIDTH  multiplier product, valid when mul_rdy rises after an operation.

Behaviour:
- Reset (asynchronous, rstb low):
  - State is S_IDLE.
  - gnt, done, result, result_id, mul_start, mul_a, mul_b, busy all 0.
  - Round-robin pointer rr_ptr is 0.
- The state machine has four registered states.
- S_IDLE:
  - Accepts when |req is high and mul_rdy is high.
  - Winner is the first set req bit scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - On accept: latch req_a/req_b slices into op_a/op_b, latch the winner into owner, assert gnt[owner] as a registered pulse in the next cycle, go to S_START.
  - With no req, or mul_rdy low, stay in S_IDLE.
- S_START:
  - mul_start is 1.
  - Stay until mul_rdy is sampled 0 (multiplier has left idle), then go to S_BUSY.
- S_BUSY:
  - mul_start is 0.
  - Wait for mul_rdy to be sampled 1. On that edge capture mul_product into result and owner into result_id, then go to S_DONE.
- S_DONE:
  - done[result_id] is 1 for exactly this cycle.
  - rr_ptr becomes (owner+1) mod N_REQ.
  - Go to S_IDLE.
- Operand hold: mul_a/mul_b are driven from op_a/op_b. They are held constant from S_START through S_DONE.
- Requester operand changes after gnt do not affect the operation in flight.
- result/result_id hold their value until the next S_DONE.
- Throughput:
  - From S_IDLE, the earliest next accept is the cycle after S_DONE.
  - Fixed overhead is 3 cycles plus the multiplier busy time.
  - With the team multiplier (1 load cycle + 2 cycles per bit), done appears 2*DP_WIDTH+3 cycles after the accept edge for DP_WIDTH=8.
- Simultaneous requests: exactly one is granted per accept. The others stay pending and are never dropped.
- Fairness: any continuously asserted req is granted within N_REQ operations.
- req still high after its gnt is treated as a new request, subject to round-robin.
- req deasserted before gnt (protocol violation) is simply not considered at the next S_IDLE evaluation. There is no error output.
- Arithmetic: the block performs none. The product width is 2*DP_WIDTH, passed through unmodified.
- Reset mid-operation: returns to S_IDLE with rr_ptr 0. No done is issued for the aborted request. The multiplier shares rstb.

Test Plan:
- Single request: req=4'b0010, a=8'd13, b=8'd11 -> gnt=4'b0010 for one cycle; done=4'b0010 with result=16'd143, result_id=1; busy falls the cycle after done.
- All four requesters request simultaneously after reset, operands (3,5),(7,9),(255,255),(0,200) -> grant order 0,1,2,3; results 15, 63, 65025, 0 with matching result_id; exactly one done per operation.
- Round-robin: req0 and req2 held continuously -> grants alternate 0,2,0,2; neither is granted twice in a row.
- Operand change after gnt: requester 1 switches a from 8'd6 to 8'd9 one cycle after gnt, b=8'd7 -> result=16'd42.
- Multiplier busy at request: hold mul_rdy low (stub) with req=4'b0001 -> no gnt until mul_rdy rises; gnt the cycle after.
- Reset mid-operation: assert rstb low while in S_BUSY -> all outputs 0 immediately; no done; after release, a pending req3 is granted with rr_ptr=0 semantics.
